// File: rtl/prg_mem_arb_if.sv
// ---------------------------------------------------------------------------
// prg_mem_arb_if
// Bundles the mapper port, the host port and the external memory port of
// the program-memory arbiter.
//
// Signals
//   map_req/map_we/map_addr/map_di   mapper request (one-cycle pulse)
//   map_do/map_rdy/map_ovf           mapper read data, done pulse, lost-request flag
//   host_req/host_we/host_addr/host_di  host request (level)
//   host_do/host_ack                 host read data, done pulse
//   mem_addr/mem_do/mem_di           external memory address and data
//   mem_ce/mem_oe/mem_we             external memory strobes, active-high
//   busy                             arbiter not idle
//
// Modports
//   slave  - the arbiter side
//   master - the requester/memory side (testbench, system glue)
// ---------------------------------------------------------------------------
interface prg_mem_arb_if;
    logic        map_req;
    logic        map_we;
    logic [22:0] map_addr;
    logic [7:0]  map_di;
    logic [7:0]  map_do;
    logic        map_rdy;
    logic        map_ovf;

    logic        host_req;
    logic        host_we;
    logic [22:0] host_addr;
    logic [7:0]  host_di;
    logic [7:0]  host_do;
    logic        host_ack;

    logic [22:0] mem_addr;
    logic [7:0]  mem_do;
    logic [7:0]  mem_di;
    logic        mem_ce;
    logic        mem_oe;
    logic        mem_we;

    logic        busy;

    modport slave (
        input  map_req, map_we, map_addr, map_di,
        output map_do, map_rdy, map_ovf,
        input  host_req, host_we, host_addr, host_di,
        output host_do, host_ack,
        output mem_addr, mem_do, mem_ce, mem_oe, mem_we,
        input  mem_di,
        output busy
    );

    modport master (
        output map_req, map_we, map_addr, map_di,
        input  map_do, map_rdy, map_ovf,
        output host_req, host_we, host_addr, host_di,
        input  host_do, host_ack,
        input  mem_addr, mem_do, mem_ce, mem_oe, mem_we,
        output mem_di,
        input  busy
    );
endinterface

// File: rtl/prg_mem_arb.sv
// ---------------------------------------------------------------------------
// prg_mem_arb
// Arbitrates a single external byte-wide memory between a mapper (one-cycle
// request pulses, strict priority, one-deep pending slot) and a host (level
// request). Each access holds the memory for T_ACC cycles followed by one
// recovery cycle in which the completion pulse is issued.
//
// Parameters
//   T_ACC  memory access length in clk cycles (2..15)
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   bus    prg_mem_arb_if.slave: mapper, host and memory signals
// ---------------------------------------------------------------------------
module prg_mem_arb #(
    parameter int unsigned T_ACC = 4
) (
    input logic          clk,
    input logic          rst,
    prg_mem_arb_if.slave bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] MAP_ACC  = 2'd1;
    localparam logic [1:0] HOST_ACC = 2'd2;
    localparam logic [1:0] REC      = 2'd3;

    localparam logic [3:0] CNT_LAST = 4'(T_ACC - 1);

    // State and access counter
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Pending mapper slot
    logic        pend_q, pend_d;
    logic        slot_we_q, slot_we_d;
    logic [22:0] slot_addr_q, slot_addr_d;
    logic [7:0]  slot_di_q, slot_di_d;

    // Fields of the access in flight (held through IDLE/REC as well)
    logic        acc_we_q, acc_we_d;
    logic [22:0] acc_addr_q, acc_addr_d;
    logic [7:0]  acc_di_q, acc_di_d;
    logic        org_map_q, org_map_d;

    logic        ovf_q, ovf_d;
    logic [7:0]  map_do_q, map_do_d;
    logic [7:0]  host_do_q, host_do_d;

    logic in_acc;
    logic arb;
    logic last;
    logic start_map;
    logic start_host;
    logic consume;
    logic accept;

    assign in_acc = (state_q == MAP_ACC) || (state_q == HOST_ACC);
    // The recovery cycle arbitrates like IDLE so queued work follows without a gap.
    assign arb    = (state_q == IDLE) || (state_q == REC);
    assign last   = in_acc && (cnt_q == CNT_LAST);

    assign start_map  = arb && (pend_q || bus.map_req);
    // After a host access the host has not yet seen host_ack, so its level
    // request is only honoured again from IDLE.
    assign start_host = arb && !start_map && bus.host_req &&
                        ((state_q == IDLE) || org_map_q);
    assign consume    = start_map && pend_q;
    assign accept     = bus.map_req && (!pend_q || consume);

    // Pending slot and overflow flag
    always_comb begin
        pend_d      = pend_q;
        slot_we_d   = slot_we_q;
        slot_addr_d = slot_addr_q;
        slot_di_d   = slot_di_q;
        ovf_d       = ovf_q;

        if (accept) begin
            slot_we_d   = bus.map_we;
            slot_addr_d = bus.map_addr;
            slot_di_d   = bus.map_di;
        end

        if (consume) begin
            // Older slot request is served first; a simultaneous new one takes its place.
            pend_d = bus.map_req;
        end else if (bus.map_req && !start_map) begin
            pend_d = 1'b1;
        end

        if (bus.map_req && pend_q && !consume) begin
            ovf_d = 1'b1;
        end
    end

    // Sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (in_acc) begin
            if (last) begin
                state_d = REC;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end else if (start_map) begin
            state_d = MAP_ACC;
            cnt_d   = 4'd0;
        end else if (start_host) begin
            state_d = HOST_ACC;
            cnt_d   = 4'd0;
        end else begin
            state_d = IDLE;
        end
    end

    // Access fields are captured only when an access starts
    always_comb begin
        acc_we_d   = acc_we_q;
        acc_addr_d = acc_addr_q;
        acc_di_d   = acc_di_q;
        org_map_d  = org_map_q;

        if (start_map) begin
            org_map_d = 1'b1;
            if (pend_q) begin
                acc_we_d   = slot_we_q;
                acc_addr_d = slot_addr_q;
                acc_di_d   = slot_di_q;
            end else begin
                acc_we_d   = bus.map_we;
                acc_addr_d = bus.map_addr;
                acc_di_d   = bus.map_di;
            end
        end else if (start_host) begin
            org_map_d  = 1'b0;
            acc_we_d   = bus.host_we;
            acc_addr_d = bus.host_addr;
            acc_di_d   = bus.host_di;
        end
    end

    // Read data capture on the final access cycle
    always_comb begin
        map_do_d  = map_do_q;
        host_do_d = host_do_q;

        if (last && !acc_we_q) begin
            if (state_q == MAP_ACC) begin
                map_do_d = bus.mem_di;
            end else begin
                host_do_d = bus.mem_di;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            slot_we_q   <= 1'b0;
            slot_addr_q <= 23'd0;
            slot_di_q   <= 8'h00;
            acc_we_q    <= 1'b0;
            acc_addr_q  <= 23'd0;
            acc_di_q    <= 8'h00;
            org_map_q   <= 1'b0;
            ovf_q       <= 1'b0;
            map_do_q    <= 8'h00;
            host_do_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            slot_we_q   <= slot_we_d;
            slot_addr_q <= slot_addr_d;
            slot_di_q   <= slot_di_d;
            acc_we_q    <= acc_we_d;
            acc_addr_q  <= acc_addr_d;
            acc_di_q    <= acc_di_d;
            org_map_q   <= org_map_d;
            ovf_q       <= ovf_d;
            map_do_q    <= map_do_d;
            host_do_q   <= host_do_d;
        end
    end

    // Outputs are decoded from registered state only, so they are glitch-free
    // relative to the request inputs.
    assign bus.mem_ce   = in_acc;
    assign bus.mem_oe   = in_acc && !acc_we_q;
    // First write cycle is address setup only.
    assign bus.mem_we   = in_acc && acc_we_q && (cnt_q != 4'd0);
    assign bus.mem_addr = acc_addr_q;
    assign bus.mem_do   = acc_di_q;

    assign bus.map_rdy  = (state_q == REC) && org_map_q;
    assign bus.host_ack = (state_q == REC) && !org_map_q;
    assign bus.map_do   = map_do_q;
    assign bus.host_do  = host_do_q;
    assign bus.map_ovf  = ovf_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
